mult_result_accumulator: RTL

//  Downstream stage of the pipelined multiplier (multipler_top).

---
 rtl/mult_result_accumulator.sv | 103 ++++++++++
 1 files changed

// File: rtl/mult_result_accumulator.sv
// Sums each group of NUM_TERMS product beats from the multiplier and queues the group sums
// in a 2-entry FIFO drained by a valid/ready handshake; beats arriving while it is full are dropped.
module mult_result_accumulator #(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned NUM_TERMS   = 4,
    parameter int unsigned GUARD_BITS  = $clog2(NUM_TERMS)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                in_valid_i,
    input  logic [2*DATA_LENGTH-1:0]            in_data_i,
    output logic                                in_ready_o,
    input  logic                                clear_i,
    output logic [2*DATA_LENGTH+GUARD_BITS-1:0] sum_o,
    output logic                                sum_valid_o,
    input  logic                                sum_ready_i,
    output logic                                busy_o,
    output logic                                drop_o
);

    localparam int unsigned SW = 2 * DATA_LENGTH + GUARD_BITS;
    localparam int unsigned CW = $clog2(NUM_TERMS);
    localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_TERMS - 1);

    logic [SW-1:0] r_acc;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_occ;
    logic          r_drop;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_last;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [SW-1:0] w_acc_sum;

    assign w_full    = (r_occ == 2'd2);
    assign w_empty   = (r_occ == 2'd0);

    // Ready depends on registered occupancy only, so a same-cycle pop never reopens a full buffer.
    assign in_ready_o = !w_full && !rst_i;

    assign w_accept  = in_valid_i && in_ready_o && !clear_i;
    assign w_last    = w_accept && (r_count == LAST_COUNT);
    assign w_push    = w_last;
    assign w_pop     = !w_empty && sum_ready_i;
    assign w_drop    = in_valid_i && !in_ready_o && !clear_i && !rst_i;
    assign w_acc_sum = r_acc + {{GUARD_BITS{1'b0}}, in_data_i};

    assign sum_valid_o = !w_empty;
    assign sum_o       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign busy_o      = (r_count != '0) || !w_empty;
    assign drop_o      = r_drop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
            r_drop   <= 1'b0;
        end else begin
            if (clear_i || w_last) begin
                r_acc   <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                r_acc   <= w_acc_sum;
                r_count <= r_count + CW'(1);
            end

            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            if (w_push && !w_pop) begin
                r_occ <= r_occ + 2'd1;
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - 2'd1;
            end

            if (w_drop) begin
                r_drop <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible through occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            r_mem[r_wr_ptr] <= w_acc_sum;
        end
    end

endmodule
